// File: rtl/shift_sched.sv
// shift_sched: controller and two-port arbiter for the 4-bit shift register
// registrodesp. It arbitrates between two requesters, loads the winning word
// into the register in parallel, then shifts it out serially over NBITS cycles.
//
// Optional feature macro: SHIFT_SCHED_RR_EN
//   defined   -> round-robin tie-break (requester not granted last wins)
//   undefined -> fixed priority (requester 0 wins ties)
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req0/1, word0/1, dir0/1 requester handshake, data word, shift direction
//   gnt0, gnt1             one-cycle grant pulse in LOAD
//   busy, done             transaction in flight / one-cycle completion pulse
//   ser_valid, ser_bit     serial output stream (ser_bit mirrors reg_s_out)
//   ser_owner              index of the current grantee
//   reg_enb, reg_dir, reg_mode, reg_d, reg_s_in  register control
//   reg_s_out              serial output of the register
module shift_sched #(
  parameter int unsigned NBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [NBITS-1:0] word0,
  input  logic [NBITS-1:0] word1,
  input  logic             dir0,
  input  logic             dir1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             ser_owner,
  output logic             reg_enb,
  output logic             reg_dir,
  output logic             reg_s_in,
  output logic [1:0]       reg_mode,
  output logic [NBITS-1:0] reg_d,
  input  logic             reg_s_out
);

  localparam int unsigned   CW       = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] MODE_SHIFT = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b10;

  logic [1:0]       state_q, state_nx;
  logic [CW-1:0]    cnt_q, cnt_nx;
  logic             win_c;
  logic             owner_nx;
  logic             dir_nx;
  logic [NBITS-1:0] word_nx;

  // Serial data is taken straight from the register; ser_valid qualifies it.
  assign ser_bit  = reg_s_out;
  // Bits shifted in behind the data are always zero.
  assign reg_s_in = 1'b0;

  // Arbitration: winner index among the currently asserted requests.
`ifdef SHIFT_SCHED_RR_EN
  logic last_q;

  always_comb begin
    win_c = req1;
    if (req0 && req1) win_c = ~last_q;
  end

  // Pointer remembers the last grantee; reset value lets requester 0 win first.
  always_ff @(posedge clk) begin
    if (rst)                               last_q <= 1'b1;
    else if (state_q == S_IDLE && (req0 || req1)) last_q <= win_c;
  end
`else
  always_comb begin
    win_c = ~req0;
  end
`endif

  // Next-state logic; the winner's word/dir/owner are captured on the IDLE exit.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    owner_nx = ser_owner;
    dir_nx   = reg_dir;
    word_nx  = reg_d;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_nx = win_c;
          dir_nx   = win_c ? dir1  : dir0;
          word_nx  = win_c ? word1 : word0;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_nx   = '0;
        state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_nx = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register plus registered Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ser_valid <= 1'b0;
      ser_owner <= 1'b0;
      reg_enb   <= 1'b0;
      reg_dir   <= 1'b0;
      reg_mode  <= MODE_SHIFT;
      reg_d     <= '0;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      gnt0      <= (state_nx == S_LOAD) && !owner_nx;
      gnt1      <= (state_nx == S_LOAD) &&  owner_nx;
      busy      <= (state_nx != S_IDLE);
      done      <= (state_nx == S_DONE);
      ser_valid <= (state_nx == S_SHIFT);
      ser_owner <= owner_nx;
      reg_enb   <= (state_nx == S_LOAD) || (state_nx == S_SHIFT);
      reg_dir   <= dir_nx;
      reg_mode  <= (state_nx == S_LOAD) ? MODE_LOAD : MODE_SHIFT;
      reg_d     <= word_nx;
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Testbench for shift_sched: includes a behavioural model of the shift register
// and a transaction-level reference (arbitration choice, serial bit order,
// cycle positions of grant/shift/done).
module tb_shift_sched;

  localparam int unsigned NBITS = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [NBITS-1:0] word0, word1;
  logic             dir0, dir1;
  logic             gnt0, gnt1, busy, done, ser_valid, ser_bit, ser_owner;
  logic             reg_enb, reg_dir, reg_s_in;
  logic [1:0]       reg_mode;
  logic [NBITS-1:0] reg_d;
  logic             reg_s_out;

  logic [NBITS-1:0] q = '0;
  int unsigned      n_checks = 0;
  int unsigned      n_pass   = 0;
  int unsigned      n_fail   = 0;
  int               last_owner = 1;

  shift_sched #(.NBITS(NBITS)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .word0(word0), .word1(word1),
    .dir0(dir0), .dir1(dir1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .ser_valid(ser_valid), .ser_bit(ser_bit), .ser_owner(ser_owner),
    .reg_enb(reg_enb), .reg_dir(reg_dir), .reg_s_in(reg_s_in),
    .reg_mode(reg_mode), .reg_d(reg_d), .reg_s_out(reg_s_out)
  );

  always #5 clk = ~clk;

  // Model of registrodesp: parallel load on mode 10, shift on mode 00.
  always @(posedge clk) begin
    if (reg_enb) begin
      if (reg_mode == 2'b10)      q <= reg_d;
      else if (reg_mode == 2'b00) q <= reg_dir ? {reg_s_in, q[NBITS-1:1]}
                                               : {q[NBITS-2:0], reg_s_in};
    end
  end
  assign reg_s_out = reg_dir ? q[0] : q[NBITS-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected winner from the arbitration rules.
  function automatic int pick(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef SHIFT_SCHED_RR_EN
      return (last_owner == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_enb"},   32'(reg_enb), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_valid"}, 32'(ser_valid), 32'd0);
    chk({tag, "_gnt"},   32'({gnt1, gnt0}), 32'd0);
  endtask

  // Called at a negedge in IDLE with at least one request high; returns at
  // the negedge of the IDLE cycle after DONE.
  task automatic run_txn();
    int               own;
    logic [NBITS-1:0] w;
    logic             d;
    int               bit_exp;
    own = pick(req0, req1);
    w   = (own == 1) ? word1 : word0;
    d   = (own == 1) ? dir1 : dir0;
    @(negedge clk);
    chk("load_gnt0",  32'(gnt0), 32'(own == 0));
    chk("load_gnt1",  32'(gnt1), 32'(own == 1));
    chk("load_busy",  32'(busy), 32'd1);
    chk("load_enb",   32'(reg_enb), 32'd1);
    chk("load_mode",  32'(reg_mode), 32'd2);
    chk("load_d",     32'(reg_d), 32'(w));
    chk("load_dir",   32'(reg_dir), 32'(d));
    chk("load_owner", 32'(ser_owner), 32'(own));
    chk("load_valid", 32'(ser_valid), 32'd0);
    last_owner = own;
    if (own == 1) req1 = 1'b0; else req0 = 1'b0;
    for (int i = 0; i < int'(NBITS); i++) begin
      bit_exp = d ? ((int'(w) >> i) & 1) : ((int'(w) >> (int'(NBITS) - 1 - i)) & 1);
      @(negedge clk);
      chk("sh_valid", 32'(ser_valid), 32'd1);
      chk("sh_bit",   32'(ser_bit), 32'(bit_exp));
      chk("sh_mode",  32'(reg_mode), 32'd0);
      chk("sh_enb",   32'(reg_enb), 32'd1);
      chk("sh_dir",   32'(reg_dir), 32'(d));
      chk("sh_sin",   32'(reg_s_in), 32'd0);
      chk("sh_owner", 32'(ser_owner), 32'(own));
      chk("sh_gnt",   32'({gnt1, gnt0}), 32'd0);
      chk("sh_done",  32'(done), 32'd0);
    end
    @(negedge clk);
    chk("dn_done",  32'(done), 32'd1);
    chk("dn_busy",  32'(busy), 32'd1);
    chk("dn_enb",   32'(reg_enb), 32'd0);
    chk("dn_valid", 32'(ser_valid), 32'd0);
    @(negedge clk);
    check_idle("post");
    chk("post_owner", 32'(ser_owner), 32'(own));
    chk("post_d",     32'(reg_d), 32'(w));
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    word0 = '0; word1 = '0;
    dir0 = 1'b0; dir1 = 1'b0;

    // Reset, then idle.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle("rst");
      chk("rst_owner", 32'(ser_owner), 32'd0);
      chk("rst_d",     32'(reg_d), 32'd0);
      chk("rst_dir",   32'(reg_dir), 32'd0);
      chk("rst_mode",  32'(reg_mode), 32'd0);
      chk("rst_sin",   32'(reg_s_in), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("idle");
    end

    // Single request, MSB first.
    req0 = 1'b1; word0 = 4'b1011; dir0 = 1'b0;
    run_txn();

    // Requester 1, LSB first.
    req1 = 1'b1; word1 = 4'b1011; dir1 = 1'b1;
    run_txn();
    dir1 = 1'b0;

    // Contention: both requesters keep re-requesting.
    word0 = 4'hA; word1 = 4'h5;
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 3; t++) begin
      run_txn();
      req0 = 1'b1; req1 = 1'b1;
    end
    req0 = 1'b0;
    while (req1) run_txn();

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      if (!req0 && ($urandom % 2 == 0)) begin
        word0 = NBITS'($urandom); dir0 = 1'($urandom); req0 = 1'b1;
      end
      if (!req1 && ($urandom % 2 == 0)) begin
        word1 = NBITS'($urandom); dir1 = 1'($urandom); req1 = 1'b1;
      end
      if (req0 || req1) run_txn();
      else begin
        @(negedge clk);
        check_idle("rnd_idle");
      end
    end
    while (req0 || req1) run_txn();

    // Reset in the second SHIFT cycle drops the transaction.
    word0 = NBITS'($urandom); dir0 = 1'($urandom); req0 = 1'b1;
    @(negedge clk);
    chk("mr_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    chk("mr_sh0", 32'(ser_valid), 32'd1);
    @(negedge clk);
    chk("mr_sh1", 32'(ser_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_owner = 1;
    check_idle("mr_rst");
    chk("mr_d", 32'(reg_d), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("mr_after");
    end
    req0 = 1'b1; word0 = 4'b0110; dir0 = 1'b1;
    run_txn();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
